// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button front end: per-key FSM state
// encoding and the debounce window lengths for the board and for simulation.
package key_debounce_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_IDLE    = 2'd0;
  localparam key_state_t ST_DN_WAIT = 2'd1;
  localparam key_state_t ST_PRESSED = 2'd2;
  localparam key_state_t ST_UP_WAIT = 2'd3;

  // 20 ms at 50 MHz on the board; a short window keeps simulation fast
  localparam logic [31:0] COUNTER_BOARD = 32'd1000000;
  localparam logic [31:0] COUNTER_SIM   = 32'd25;

endpackage

// File: rtl/key_debounce_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and stability counter.
// Produces the debounced level and one-cycle press/release pulses, all registered.
module key_filter_ch
  import key_debounce_pkg::*;
#(
  parameter logic [31:0] COUNTER = COUNTER_BOARD,
  parameter int          CNT_W   = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_sync;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic             w_ks;
  key_state_t       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_level_nx;
  logic             w_press_nx;
  logic             w_release_nx;

  assign w_ks = r_sync[1];

  // Next-state logic: any bounce in a wait state restarts the full window
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_level_nx   = r_level;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_ks) begin
          w_state_nx = ST_DN_WAIT;
          w_cnt_nx   = '0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_DN_WAIT: begin
        if (w_ks) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = ST_PRESSED;
          w_cnt_nx   = '0;
          w_level_nx = 1'b1;
          w_press_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (w_ks) begin
          w_state_nx = ST_UP_WAIT;
          w_cnt_nx   = '0;
        end else begin
          w_state_nx = ST_PRESSED;
        end
      end
      ST_UP_WAIT: begin
        if (!w_ks) begin
          w_state_nx = ST_PRESSED;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx   = ST_IDLE;
          w_cnt_nx     = '0;
          w_level_nx   = 1'b0;
          w_release_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_level_nx = 1'b0;
      end
    endcase
  end

  // Synchroniser resets to "released" so no pulse follows reset with keys up
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= 2'b11;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_level   <= w_level_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: KEY_W independent debounce channels on raw active-low
// pins, giving active-high levels, press/release pulses and a combined press flag.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int          KEY_W   = 2,
  parameter logic [31:0] COUNTER = COUNTER_BOARD,
  parameter int          CNT_W   = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic             key_any
);

  for (genvar g = 0; g < KEY_W; g++) begin : g_ch
    key_filter_ch #(
      .COUNTER (COUNTER),
      .CNT_W   (CNT_W)
    ) u_ch (
      .i_clk     (sys_clk),
      .i_rst     (sys_rst),
      .i_key_n   (key[g]),
      .o_level   (key_level[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g])
    );
  end

  // OR of registered pulses, so it lines up with key_press in the same cycle
  assign key_any = |key_press;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with the short simulation window (25 cycles).
`timescale 1ns/100ps
module tb_key_debounce;
  import key_debounce_pkg::*;

  localparam int LAT = 27;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] key;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic       key_any;

  int tests_run    = 0;
  int tests_failed = 0;

  int         press_cnt [2];
  int         release_cnt [2];
  int         any_cnt;
  int         width_viol;
  int         excl_viol;
  int         any_viol;
  logic [1:0] prev_press;
  logic [1:0] prev_release;

  key_debounce #(
    .KEY_W   (2),
    .COUNTER (COUNTER_SIM),
    .CNT_W   (32)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key         (key),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_any     (key_any)
  );

  always #1 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #0.5;
  endtask

  // Returns the index of the first sampled edge showing the pulse (1 = edge that
  // first samples the new pin value), or -1 when the bound expires.
  task automatic wait_pulse(input int idx, input bit rel, output int n);
    bit hit;
    hit = 1'b0;
    n   = -1;
    for (int c = 1; c <= 100 && !hit; c++) begin
      @(posedge sys_clk);
      #0.5;
      if (rel ? key_release[idx] : key_press[idx]) begin
        hit = 1'b1;
        n   = c;
      end
    end
  endtask

  // Pulse monitor: counts pulses and records protocol violations every cycle
  initial begin
    for (int i = 0; i < 2; i++) begin
      press_cnt[i]   = 0;
      release_cnt[i] = 0;
    end
    any_cnt      = 0;
    width_viol   = 0;
    excl_viol    = 0;
    any_viol     = 0;
    prev_press   = 2'b00;
    prev_release = 2'b00;
    forever begin
      @(posedge sys_clk);
      #0.5;
      if (sys_rst) begin
        prev_press   = 2'b00;
        prev_release = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          press_cnt[i]   += int'(key_press[i]);
          release_cnt[i] += int'(key_release[i]);
        end
        any_cnt += int'(key_any);
        if (((key_press & prev_press) | (key_release & prev_release)) != 2'b00) width_viol++;
        if ((key_press & key_release) != 2'b00) excl_viol++;
        if (key_any !== (|key_press)) any_viol++;
        prev_press   = key_press;
        prev_release = key_release;
      end
    end
  end

  initial begin
    int n;
    int base_a;
    int base_b;

    // 1: reset state and quiet period with keys released
    sys_rst = 1'b1;
    key     = 2'b11;
    #19.5;
    check_eq("rst_level",   32'(key_level),   32'd0);
    check_eq("rst_press",   32'(key_press),   32'd0);
    check_eq("rst_release", 32'(key_release), 32'd0);
    check_eq("rst_any",     32'(key_any),     32'd0);
    #0.5;
    sys_rst = 1'b0;
    cycles(200);
    check_eq("idle_pulses", 32'(press_cnt[0] + press_cnt[1] + release_cnt[0] + release_cnt[1] + any_cnt), 32'd0);
    check_eq("idle_level",  32'(key_level), 32'd0);

    // 2: clean press on key 0
    base_a = press_cnt[0];
    @(negedge sys_clk) key[0] = 1'b0;
    wait_pulse(0, 1'b0, n);
    check_eq("t2_press_lat", 32'(n - 1), 32'(LAT));
    check_eq("t2_level",     32'(key_level[0]), 32'd1);
    cycles(40);
    check_eq("t2_single",    32'(press_cnt[0] - base_a), 32'd1);

    // 3: key 1 bounces before settling low
    base_a = press_cnt[1];
    @(negedge sys_clk) key[1] = 1'b0;
    repeat (10) @(negedge sys_clk);
    key[1] = 1'b1;
    repeat (3) @(negedge sys_clk);
    key[1] = 1'b0;
    wait_pulse(1, 1'b0, n);
    check_eq("t3_press_lat", 32'(n - 1), 32'(LAT));
    cycles(5);
    check_eq("t3_single",    32'(press_cnt[1] - base_a), 32'd1);

    // 4: key 0 release with a 5-cycle glitch back low
    base_a = release_cnt[0];
    base_b = press_cnt[0];
    @(negedge sys_clk) key[0] = 1'b1;
    repeat (10) @(negedge sys_clk);
    key[0] = 1'b0;
    repeat (5) @(negedge sys_clk);
    key[0] = 1'b1;
    wait_pulse(0, 1'b1, n);
    check_eq("t4_rel_lat",   32'(n - 1), 32'(LAT));
    check_eq("t4_level",     32'(key_level[0]), 32'd0);
    cycles(5);
    check_eq("t4_rel_once",  32'(release_cnt[0] - base_a), 32'd1);
    check_eq("t4_no_repress", 32'(press_cnt[0] - base_b), 32'd0);

    // 5: release key 1, then press both keys on the same edge
    @(negedge sys_clk) key[1] = 1'b1;
    wait_pulse(1, 1'b1, n);
    check_eq("t5_rel1_lat",  32'(n - 1), 32'(LAT));
    cycles(5);
    base_a = any_cnt;
    @(negedge sys_clk) key = 2'b00;
    wait_pulse(0, 1'b0, n);
    check_eq("t5_press_lat", 32'(n - 1), 32'(LAT));
    check_eq("t5_press_both", 32'(key_press), 32'd3);
    check_eq("t5_any",       32'(key_any), 32'd1);
    cycles(5);
    check_eq("t5_any_once",  32'(any_cnt - base_a), 32'd1);
    check_eq("t5_level",     32'(key_level), 32'd3);

    // 6: asynchronous reset while pressed, then re-qualification of held keys
    cycles(10);
    @(negedge sys_clk) sys_rst = 1'b1;
    #0.2;
    check_eq("t6_async_level", 32'(key_level), 32'd0);
    check_eq("t6_async_press", 32'(key_press), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk) sys_rst = 1'b0;
    wait_pulse(0, 1'b0, n);
    check_eq("t6_press_lat", 32'(n - 1), 32'(LAT));
    check_eq("t6_press_both", 32'(key_press), 32'd3);
    cycles(5);

    check_eq("pulse_width",  32'(width_viol), 32'd0);
    check_eq("press_rel_excl", 32'(excl_viol), 32'd0);
    check_eq("any_or",       32'(any_viol),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
